// File: rtl/pulse_counter.sv
// pulse_counter: free-running modulo-MODULUS up-counter with terminal-count
// decode and a sticky wrap flag. Asynchronous active-low clear loads INIT.
//
// Optional build macro: PULSE_COUNTER_GRAY_EN
//   When defined, adds output 'gray', a registered Gray code of the count
//   that updates on the same edge as the count itself.
//
// Parameters:
//   WIDTH   : count width, 1..32
//   MODULUS : sequence length, 2..2**WIDTH
//   INIT    : value loaded by clear, must be < MODULUS
module pulse_counter #(
    parameter int unsigned     WIDTH   = 1,
    parameter longint unsigned MODULUS = 2,
    parameter longint unsigned INIT    = 0
) (
    input  logic             clk,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped
`ifdef PULSE_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] gray
`endif
);

    // MODULUS may be as large as 2**32, so the range limit is held in 64 bits.
    localparam longint unsigned MAX_MODULUS = 64'd1 << WIDTH;

    // Terminal value and reset value, both reduced to WIDTH bits so every
    // compare happens at the counter width. For MODULUS == 2**WIDTH the
    // terminal value is all-ones and the wrap still goes through the compare.
    localparam logic [WIDTH-1:0] LAST   = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    // Reject illegal parameter combinations at elaboration.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("pulse_counter: WIDTH=%0d outside 1..32", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > MAX_MODULUS) begin : g_bad_modulus
        $error("pulse_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
    end
    if (INIT >= MODULUS) begin : g_bad_init
        $error("pulse_counter: INIT=%0d must be below MODULUS=%0d", INIT, MODULUS);
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrapped_q;
    logic             wrapped_d;
    logic             at_last;

    // Next-state: step by one, wrapping to zero (not INIT) after the last value.
    always_comb begin
        at_last   = (count_q == LAST);
        count_d   = at_last ? '0 : (count_q + ONE);
        wrapped_d = wrapped_q | at_last;
    end

    // State registers; clear overrides the clock and holds the reset state.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            count_q   <= INIT_V;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign count   = count_q;
    assign tc      = at_last;
    assign wrapped = wrapped_q;

`ifdef PULSE_COUNTER_GRAY_EN
    localparam logic [WIDTH-1:0] GRAY_INIT = INIT_V ^ (INIT_V >> 1);

    logic [WIDTH-1:0] gray_q;

    // Encode the next count so the Gray output lands on the same edge as count.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            gray_q <= GRAY_INIT;
        end else begin
            gray_q <= count_d ^ (count_d >> 1);
        end
    end

    assign gray = gray_q;
`endif

endmodule

// File: tb/tb_pulse_counter.sv
// Testbench for pulse_counter. Four instances with different parameter sets
// share one clock and one clear; a reference model pushes expected outputs
// into a scoreboard queue and each sample point pops and compares them.
module tb_pulse_counter;

    localparam int N_INST = 4;
    localparam int LAST_A [N_INST] = '{1, 4, 15, 7};
    localparam int INIT_A [N_INST] = '{0, 2, 0, 0};

    typedef struct {
        int         inst;
        logic [3:0] cnt;
        logic       tc;
        logic       wr;
        logic [3:0] gry;
    } exp_t;

    exp_t sb[$];

    logic clk   = 1'b0;
    logic clear = 1'b1;

    logic [0:0] c0;
    logic [2:0] c1;
    logic [3:0] c2;
    logic [2:0] c3;
    logic       tc0, tc1, tc2, tc3;
    logic       w0, w1, w2, w3;
`ifdef PULSE_COUNTER_GRAY_EN
    logic [0:0] g0;
    logic [2:0] g1;
    logic [3:0] g2;
    logic [2:0] g3;
`endif

    int m_cnt  [N_INST];
    bit m_wrap [N_INST];
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pulse_counter u0 (
        .clk(clk), .clear(clear), .count(c0), .tc(tc0), .wrapped(w0)
`ifdef PULSE_COUNTER_GRAY_EN
        , .gray(g0)
`endif
    );

    pulse_counter #(.WIDTH(3), .MODULUS(5), .INIT(2)) u1 (
        .clk(clk), .clear(clear), .count(c1), .tc(tc1), .wrapped(w1)
`ifdef PULSE_COUNTER_GRAY_EN
        , .gray(g1)
`endif
    );

    pulse_counter #(.WIDTH(4), .MODULUS(16), .INIT(0)) u2 (
        .clk(clk), .clear(clear), .count(c2), .tc(tc2), .wrapped(w2)
`ifdef PULSE_COUNTER_GRAY_EN
        , .gray(g2)
`endif
    );

    pulse_counter #(.WIDTH(3), .MODULUS(8), .INIT(0)) u3 (
        .clk(clk), .clear(clear), .count(c3), .tc(tc3), .wrapped(w3)
`ifdef PULSE_COUNTER_GRAY_EN
        , .gray(g3)
`endif
    );

    task automatic model_reset();
        for (int i = 0; i < N_INST; i++) begin
            m_cnt[i]  = INIT_A[i];
            m_wrap[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N_INST; i++) begin
            if (m_cnt[i] == LAST_A[i]) begin
                m_cnt[i]  = 0;
                m_wrap[i] = 1'b1;
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
    endtask

    task automatic push_all();
        exp_t e;
        for (int i = 0; i < N_INST; i++) begin
            e.inst = i;
            e.cnt  = 4'(m_cnt[i]);
            e.tc   = (m_cnt[i] == LAST_A[i]);
            e.wr   = m_wrap[i];
            e.gry  = 4'(m_cnt[i] ^ (m_cnt[i] >> 1));
            sb.push_back(e);
        end
    endtask

    task automatic check_all(input string tag);
        exp_t       e;
        logic [3:0] o_cnt;
        logic       o_tc;
        logic       o_wr;
        logic [3:0] o_gry;
        while (sb.size() > 0) begin
            e     = sb.pop_front();
            o_gry = 4'd0;
            case (e.inst)
                0: begin o_cnt = {3'd0, c0}; o_tc = tc0; o_wr = w0; end
                1: begin o_cnt = {1'b0, c1}; o_tc = tc1; o_wr = w1; end
                2: begin o_cnt = c2;         o_tc = tc2; o_wr = w2; end
                default: begin o_cnt = {1'b0, c3}; o_tc = tc3; o_wr = w3; end
            endcase
`ifdef PULSE_COUNTER_GRAY_EN
            case (e.inst)
                0: o_gry = {3'd0, g0};
                1: o_gry = {1'b0, g1};
                2: o_gry = g2;
                default: o_gry = {1'b0, g3};
            endcase
`endif
            total++;
            assert (o_cnt === e.cnt) passed++;
            else $error("FAIL %s u%0d count: got %0d want %0d", tag, e.inst, o_cnt, e.cnt);
            total++;
            assert (o_tc === e.tc) passed++;
            else $error("FAIL %s u%0d tc: got %b want %b", tag, e.inst, o_tc, e.tc);
            total++;
            assert (o_wr === e.wr) passed++;
            else $error("FAIL %s u%0d wrapped: got %b want %b", tag, e.inst, o_wr, e.wr);
`ifdef PULSE_COUNTER_GRAY_EN
            total++;
            assert (o_gry === e.gry) passed++;
            else $error("FAIL %s u%0d gray: got %b want %b", tag, e.inst, o_gry, e.gry);
`endif
        end
    endtask

    // One clock edge: advance the model if clear was high at the edge, then
    // sample 1 time unit later.
    task automatic tick(input string tag);
        bit         en;
        logic [2:0] prev_g;
        en     = clear;
        prev_g = 3'(m_cnt[3] ^ (m_cnt[3] >> 1));
        @(posedge clk);
        if (en) model_step();
        #1;
        push_all();
        check_all(tag);
`ifdef PULSE_COUNTER_GRAY_EN
        if (en) begin
            total++;
            assert ($countones(g3 ^ prev_g) == 1) passed++;
            else $error("FAIL %s u3 gray_one_bit: got %b after %b want 1 bit change", tag, g3, prev_g);
        end
`else
        if (prev_g === 3'bxxx) $write("");
`endif
    endtask

    initial begin
        // Asynchronous clear before any clock edge.
        #2 clear = 1'b0;
        model_reset();
        #1;
        push_all();
        check_all("reset_async");

        // Clear held across several edges: nothing moves.
        repeat (3) tick("reset_held");

        // Release coincident with a posedge: the flops still sample clear low
        // on this edge, so the first increment is on the following edge.
        @(posedge clk);
        clear <= 1'b1;
        #1;
        push_all();
        check_all("release_edge");

        // Count 19 steps: u0 toggles, u1 wraps 4->0, u2 runs 0..15 then 0..3,
        // u3 wraps at 8 and ends at 3.
        for (int k = 0; k < 19; k++) tick($sformatf("run%0d", k));

        // Clear mid-cycle, well away from any clock edge.
        #3 clear = 1'b0;
        model_reset();
        #1;
        push_all();
        check_all("clear_mid");

        repeat (3) tick("clear_hold");

        // Ordinary release between edges, then count again.
        @(negedge clk);
        clear = 1'b1;
        for (int k = 0; k < 6; k++) tick($sformatf("rerun%0d", k));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
